// File: rtl/ws2812_pattern_driver.sv
`timescale 1ns/1ps
// WS2812B chain driver: serialises NUM_LEDS GRB pixels from an external source or an
// internal solid/chase/rainbow pattern, with global brightness scaling and a frame phase.
module ws2812_pattern_driver #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned SYSTEM_CLOCK = 25000000,
  parameter int unsigned RESET_US     = 80,
  localparam int unsigned AW = ($clog2(NUM_LEDS) > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [7:0]    brightness,
  input  logic [7:0]    red_in,
  input  logic [7:0]    green_in,
  input  logic [7:0]    blue_in,
  output logic [AW-1:0] address,
  output logic          DO,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    phase
);

  localparam int unsigned CYC_BIT  = SYSTEM_CLOCK / 800000;
  localparam int unsigned CYC_T0H  = SYSTEM_CLOCK / 2500000;
  localparam int unsigned CYC_T1H  = SYSTEM_CLOCK / 1250000;
  localparam int unsigned CYC_RST  = (SYSTEM_CLOCK / 1000000) * RESET_US;
  localparam int unsigned HUE_STEP = 256 / NUM_LEDS;
  localparam int unsigned CNT_MAX  = (CYC_RST > CYC_BIT) ? CYC_RST : CYC_BIT;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(CYC_BIT - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(CYC_RST - 1);
  localparam logic [CW-1:0] T0H      = CW'(CYC_T0H);
  localparam logic [CW-1:0] T1H      = CW'(CYC_T1H);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_LEDS - 1);
  localparam logic [7:0]    HUE8     = 8'(HUE_STEP);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StSend, StLatch} state_e;

  state_e        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [4:0]    r_bit, w_bit_n;
  logic [AW-1:0] r_idx, w_idx_n;
  logic [23:0]   r_shift, w_shift_n;
  logic [1:0]    r_mode, w_mode_n;
  logic [7:0]    r_bright, w_bright_n;
  logic [23:0]   r_base, w_base_n;
  logic [7:0]    r_phase, w_phase_n;
  logic          r_do, w_do_n;
  logic          w_done;

  logic [23:0]   w_cap, w_solid, w_col, w_pixel;
  logic [31:0]   w_lit;
  logic [7:0]    w_hue;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(p >> 8);
  endfunction

  // Colour wheel, returned as {R,G,B}.
  function automatic logic [23:0] wheel(input logic [7:0] h);
    logic [7:0] k;
    k = 8'd0;
    if (h < 8'd85) begin
      return {8'd255 - h * 8'd3, h * 8'd3, 8'd0};
    end else if (h < 8'd170) begin
      k = h - 8'd85;
      return {8'd0, 8'd255 - k * 8'd3, k * 8'd3};
    end else begin
      k = h - 8'd170;
      return {k * 8'd3, 8'd0, 8'd255 - k * 8'd3};
    end
  endfunction

  always_comb begin
    w_col   = 24'd0;
    w_cap   = {red_in, green_in, blue_in};
    w_solid = (r_idx == '0) ? w_cap : r_base;
    w_lit   = {24'd0, r_phase} % NUM_LEDS;
    w_hue   = r_phase + 8'(r_idx) * HUE8;
    unique case (r_mode)
      2'd0:    w_col = w_cap;
      2'd1:    w_col = w_solid;
      2'd2:    w_col = (w_lit == 32'(r_idx)) ? w_solid : 24'd0;
      default: w_col = wheel(w_hue);
    endcase
    w_pixel = {scale(w_col[15:8], r_bright), scale(w_col[23:16], r_bright),
               scale(w_col[7:0], r_bright)};
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_bit_n    = r_bit;
    w_idx_n    = r_idx;
    w_shift_n  = r_shift;
    w_mode_n   = r_mode;
    w_bright_n = r_bright;
    w_base_n   = r_base;
    w_phase_n  = r_phase;
    w_done     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (enable) begin
          w_state_n  = StFetch;
          w_idx_n    = '0;
          w_mode_n   = mode;
          w_bright_n = brightness;
        end
      end
      StFetch: w_state_n = StLoad;
      StLoad: begin
        w_shift_n = w_pixel;
        w_cnt_n   = '0;
        w_bit_n   = 5'd0;
        if (r_idx == '0) w_base_n = w_cap;
        w_state_n = StSend;
      end
      StSend: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_n   = '0;
          w_shift_n = {r_shift[22:0], 1'b0};
          w_bit_n   = r_bit + 5'd1;
          if (r_bit == 5'd23) begin
            w_bit_n = 5'd0;
            if (r_idx == IDX_LAST) begin
              w_state_n = StLatch;
            end else begin
              w_idx_n   = r_idx + 1'b1;
              w_state_n = StFetch;
            end
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      StLatch: begin
        if (r_cnt == RST_LAST) begin
          w_done    = 1'b1;
          w_phase_n = r_phase + 8'd1;
          w_cnt_n   = '0;
          // Restart in the same cycle keeps frames strictly back-to-back.
          if (enable) begin
            w_state_n  = StFetch;
            w_idx_n    = '0;
            w_mode_n   = mode;
            w_bright_n = brightness;
          end else begin
            w_state_n = StIdle;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = StIdle;
    endcase
    // DO is registered from next-state so the pin is glitch-free yet aligned to the state.
    w_do_n = (w_state_n == StSend) && (w_cnt_n < (w_shift_n[23] ? T1H : T0H));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_bit    <= 5'd0;
      r_idx    <= '0;
      r_shift  <= 24'd0;
      r_mode   <= 2'd0;
      r_bright <= 8'd0;
      r_base   <= 24'd0;
      r_phase  <= 8'd0;
      r_do     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_bit    <= w_bit_n;
      r_idx    <= w_idx_n;
      r_shift  <= w_shift_n;
      r_mode   <= w_mode_n;
      r_bright <= w_bright_n;
      r_base   <= w_base_n;
      r_phase  <= w_phase_n;
      r_do     <= w_do_n;
    end
  end

  assign address    = r_idx;
  assign DO         = r_do;
  assign busy       = (r_state != StIdle);
  assign frame_done = w_done;
  assign phase      = r_phase;

endmodule

// File: tb/tb_ws2812_pattern_driver.sv
`timescale 1ns/1ps
// Directed bench: A = 2 LEDs at 25 MHz, B = 4 LEDs at 2.5 MHz, C = 1 LED at 2.5 MHz / 50 us.
module tb_ws2812_pattern_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_a, en_b, en_c;
  logic [1:0] mode;
  logic [7:0] bright, red, green, blue_drv, blue_a;
  logic       ext_sel;

  logic [0:0] addr_a, addr_c;
  logic [1:0] addr_b;
  logic       do_a, do_b, do_c, busy_a, busy_b, busy_c, fd_a, fd_b, fd_c;
  logic [7:0] phase_a, phase_b, phase_c;

  // External pixel memory for A: address-dependent blue when ext_sel is set.
  assign blue_a = ext_sel ? (addr_a[0] ? 8'hF0 : 8'h0F) : blue_drv;

  ws2812_pattern_driver #(.NUM_LEDS(2), .SYSTEM_CLOCK(25000000), .RESET_US(80)) u_a (
    .clk(clk), .reset(rst_n), .enable(en_a), .mode(mode), .brightness(bright),
    .red_in(red), .green_in(green), .blue_in(blue_a), .address(addr_a), .DO(do_a),
    .busy(busy_a), .frame_done(fd_a), .phase(phase_a));

  ws2812_pattern_driver #(.NUM_LEDS(4), .SYSTEM_CLOCK(2500000), .RESET_US(80)) u_b (
    .clk(clk), .reset(rst_n), .enable(en_b), .mode(mode), .brightness(bright),
    .red_in(red), .green_in(green), .blue_in(blue_drv), .address(addr_b), .DO(do_b),
    .busy(busy_b), .frame_done(fd_b), .phase(phase_b));

  ws2812_pattern_driver #(.NUM_LEDS(1), .SYSTEM_CLOCK(2500000), .RESET_US(50)) u_c (
    .clk(clk), .reset(rst_n), .enable(en_c), .mode(mode), .brightness(bright),
    .red_in(red), .green_in(green), .blue_in(blue_drv), .address(addr_c), .DO(do_c),
    .busy(busy_c), .frame_done(fd_c), .phase(phase_c));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [95:0] cap_bits;
  int hi_len[96];
  int lo_len[96];

  function automatic logic get_do(input int sel);
    case (sel)
      0: return do_a;
      1: return do_b;
      default: return do_c;
    endcase
  endfunction

  function automatic logic get_fd(input int sel);
    case (sel)
      0: return fd_a;
      1: return fd_b;
      default: return fd_c;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_busy(input int sel);
    int t = 0;
    while (!get_busy(sel) && t < 50) begin tick(1); t++; end
    n_cmp++;
    if (get_busy(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise[%0d]: busy=%b after %0d cycles, want 1", sel, get_busy(sel), t);
    end
  endtask

  task automatic wait_fd(input int sel, input int budget);
    int t = 0;
    while (!get_fd(sel) && t < budget) begin tick(1); t++; end
    n_cmp++;
    if (get_fd(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done_wait[%0d]: no pulse within %0d cycles, want pulse", sel, budget);
    end
  endtask

  // Decodes nbits of DO by pulse width; records high/low run lengths per bit.
  task automatic capture(input int sel, input int nbits, input int thr, input int budget);
    int t, h, l;
    cap_bits = '0;
    t = 0;
    while (!get_do(sel) && t < budget) begin tick(1); t++; end
    n_cmp++;
    if (get_do(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_start[%0d]: DO low for %0d cycles, want a pulse", sel, t);
      return;
    end
    for (int j = 0; j < nbits; j++) begin
      h = 0;
      while (get_do(sel) && h < budget) begin tick(1); h++; end
      l = 0;
      if (j < nbits - 1) begin
        while (!get_do(sel) && l < budget) begin tick(1); l++; end
      end
      hi_len[j] = h;
      lo_len[j] = l;
      cap_bits[nbits-1-j] = (h >= thr);
      if (h >= budget || l >= budget) begin
        n_cmp++; n_fail++;
        $display("FAIL capture_bit[%0d]: bit %0d stuck (high %0d low %0d), want toggling", sel, j, h, l);
        return;
      end
    end
  endtask

  task automatic test_reset();
    int t;
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    mode = 2'd0; bright = 8'd255; red = 8'hFF; green = 8'h00; blue_drv = 8'h00; ext_sel = 1'b1;
    tick(3);
    n_cmp++; if (do_a !== 1'b0) begin n_fail++; $display("FAIL reset_do: got %b want 0", do_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", fd_a); end
    n_cmp++; if (phase_a !== 8'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase_a); end
    n_cmp++; if (addr_a !== 1'b0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
    // Assert reset asynchronously while DO is high in SEND.
    rst_n = 1'b1;
    tick(1);
    en_a = 1'b1;
    t = 0;
    while (do_a !== 1'b1 && t < 50) begin tick(1); t++; end
    n_cmp++; if (do_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_do: got %b want 1", do_a); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (do_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_do: got %b want 0", do_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy_a); end
    en_a = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_external_frame();
    int t0, len, bad, eh, el;
    logic [47:0] expv;
    reset_all();
    mode = 2'd0; ext_sel = 1'b1; red = 8'hFF; green = 8'h00; bright = 8'd255;
    expv = {24'h00FF0F, 24'h00FFF0};
    en_a = 1'b1;
    wait_busy(0);
    t0 = cyc;
    en_a = 1'b0;
    capture(0, 48, 15, 5000);
    n_cmp++;
    if (cap_bits[47:0] !== expv) begin
      n_fail++; $display("FAIL ext_data: got %h want %h", cap_bits[47:0], expv);
    end
    bad = 0;
    for (int j = 0; j < 48; j++) begin
      eh = expv[47-j] ? 20 : 10;
      el = 31 - eh + ((j % 24 == 23) ? 2 : 0);
      if (hi_len[j] != eh) bad++;
      if (j < 47 && lo_len[j] != el) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL ext_bit_timing: %0d bad widths, want 0", bad); end
    wait_fd(0, 5000);
    len = cyc - t0 + 1;
    n_cmp++; if (len !== 3492) begin n_fail++; $display("FAIL frame_len: got %0d want 3492", len); end
    tick(1);
    n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("FAIL fd_one_cycle: got %b want 0", fd_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ext_idle_busy: got %b want 0", busy_a); end
    n_cmp++; if (phase_a !== 8'd1) begin n_fail++; $display("FAIL ext_phase: got %0d want 1", phase_a); end
    ext_sel = 1'b0;
  endtask

  task automatic test_solid_brightness();
    int bad;
    reset_all();
    mode = 2'd1; red = 8'hFF; green = 8'h00; blue_drv = 8'h00; bright = 8'd127;
    en_a = 1'b1;
    wait_busy(0);
    en_a = 1'b0;
    fork
      begin tick(200); red = 8'h00; green = 8'hAA; end
      capture(0, 48, 15, 5000);
    join
    n_cmp++;
    if (cap_bits[47:0] !== 48'h007F00_007F00) begin
      n_fail++; $display("FAIL solid_b127: got %h want 007f00007f00", cap_bits[47:0]);
    end
    wait_fd(0, 5000);
    tick(2);
    bright = 8'd0; red = 8'hFF; green = 8'h00;
    en_a = 1'b1;
    wait_busy(0);
    en_a = 1'b0;
    capture(0, 48, 15, 5000);
    n_cmp++;
    if (cap_bits[47:0] !== 48'h0) begin
      n_fail++; $display("FAIL solid_b0: got %h want 0", cap_bits[47:0]);
    end
    bad = 0;
    for (int j = 0; j < 48; j++) if (hi_len[j] != 10) bad++;
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL b0_zero_codes: %0d wide pulses, want 0", bad); end
    wait_fd(0, 5000);
    tick(2);
  endtask

  task automatic test_chase();
    logic [95:0] expv;
    reset_all();
    mode = 2'd2; red = 8'h34; green = 8'h12; blue_drv = 8'h56; bright = 8'd255;
    en_b = 1'b1;
    for (int f = 0; f < 5; f++) begin
      capture(1, 96, 2, 1000);
      expv = '0;
      expv[95 - 24 * (f % 4) -: 24] = 24'h123456;
      n_cmp++;
      if (cap_bits !== expv) begin
        n_fail++; $display("FAIL chase_frame%0d: got %h want %h", f, cap_bits, expv);
      end
      if (f == 4) en_b = 1'b0;
    end
    wait_fd(1, 1000);
    tick(1);
    n_cmp++; if (phase_b !== 8'd5) begin n_fail++; $display("FAIL chase_phase: got %0d want 5", phase_b); end
    n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL chase_idle: got %b want 0", busy_b); end
  endtask

  task automatic test_rainbow();
    logic [95:0] expv;
    reset_all();
    mode = 2'd3; bright = 8'd255;
    expv = {24'h00FF00, 24'hC03F00, 24'h7E0081, 24'h0042BD};
    en_b = 1'b1;
    wait_busy(1);
    en_b = 1'b0;
    capture(1, 96, 2, 1000);
    n_cmp++;
    if (cap_bits !== expv) begin n_fail++; $display("FAIL rainbow: got %h want %h", cap_bits, expv); end
    wait_fd(1, 1000);
    tick(2);
  endtask

  task automatic test_drop_enable();
    int t, l;
    reset_all();
    mode = 2'd1; red = 8'hFF; green = 8'h00; blue_drv = 8'h0F; bright = 8'd255;
    en_a = 1'b1;
    wait_busy(0);
    fork
      begin
        tick(50);
        mode = 2'd3; bright = 8'd0;
        t = 0;
        while (addr_a !== 1'b1 && t < 2000) begin tick(1); t++; end
        tick(100);
        en_a = 1'b0;
      end
      capture(0, 48, 15, 5000);
    join
    n_cmp++;
    if (cap_bits[47:0] !== 48'h00FF0F_00FF0F) begin
      n_fail++; $display("FAIL drop_data: got %h want 00ff0f00ff0f", cap_bits[47:0]);
    end
    // Last bit is a 1: 11 low cycles of its own, then the latch.
    l = 1;
    while (!fd_a && l < 3000) begin tick(1); l++; end
    n_cmp++; if (l !== 2011) begin n_fail++; $display("FAIL latch_low: got %0d want 2011", l); end
    tick(1);
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b want 0", busy_a); end
    tick(50);
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL drop_stay_idle: got %b want 0", busy_a); end
    n_cmp++; if (phase_a !== 8'd1) begin n_fail++; $display("FAIL drop_phase: got %0d want 1", phase_a); end
  endtask

  task automatic test_back_to_back();
    int tfirst;
    reset_all();
    mode = 2'd1; red = 8'h01; green = 8'h02; blue_drv = 8'h03; bright = 8'd255;
    en_c = 1'b1;
    tfirst = 0;
    for (int f = 1; f <= 256; f++) begin
      wait_fd(2, 400);
      if (f == 1) tfirst = cyc;
      if (f == 2) begin
        n_cmp++;
        if (cyc - tfirst !== 174) begin
          n_fail++; $display("FAIL b2b_period: got %0d want 174", cyc - tfirst);
        end
      end
      tick(1);
      if (f == 255) begin
        n_cmp++;
        if (phase_c !== 8'd255) begin n_fail++; $display("FAIL phase_255: got %0d want 255", phase_c); end
      end
    end
    en_c = 1'b0;
    n_cmp++; if (phase_c !== 8'd0) begin n_fail++; $display("FAIL phase_wrap: got %0d want 0", phase_c); end
    n_cmp++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b want 1", busy_c); end
    wait_fd(2, 400);
    tick(1);
    n_cmp++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", busy_c); end
    n_cmp++; if (phase_c !== 8'd1) begin n_fail++; $display("FAIL b2b_phase: got %0d want 1", phase_c); end
  endtask

  initial begin
    test_reset();
    test_external_frame();
    test_solid_brightness();
    test_chase();
    test_rainbow();
    test_drop_enable();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_pattern_driver.md
Name: ws2812_pattern_driver

Overview:
Self-contained WS2812B chain driver with a built-in animation engine. It serialises 24-bit GRB pixels for a parametrised number of LEDs using timing derived from SYSTEM_CLOCK. Pixel colours come either from an external address/colour interface or from internal patterns: solid, chase or rainbow. Global brightness scaling and a per-frame animation phase are included. It sits at board top level driving the LED data pin directly.

Parameters:
NUM_LEDS, 8, LEDs in the chain (>=1)
SYSTEM_CLOCK, 25000000, clk frequency in Hz
RESET_US, 80, latch low time in microseconds (>=50)
Derived localparams: CYC_BIT=SYSTEM_CLOCK/800000; CYC_T0H=SYSTEM_CLOCK/2500000; CYC_T1H=SYSTEM_CLOCK/1250000; CYC_RST=(SYSTEM_CLOCK/1000000)*RESET_US; AW=max(1,$clog2(NUM_LEDS)); HUE_STEP=256/NUM_LEDS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  frames run back-to-back while high
mode  in  2  0 external, 1 solid, 2 chase, 3 rainbow
brightness  in  8  global scale factor
red_in  in  8  external/solid/chase colour
green_in  in  8  "
blue_in  in  8  "
address  out  AW  pixel index being fetched
DO  out  1  serial data to the first LED
busy  out  1  high from FETCH through LATCH
frame_done  out  1  one-cycle pulse at the end of LATCH
phase  out  8  animation phase

Behaviour:
- Reset (async, low): DO=0, busy=0, frame_done=0, phase=0, address=0, FSM=IDLE, all counters 0. Reset asserted mid-bit forces DO low without waiting for clk.
- FSM: IDLE -> FETCH -> LOAD -> SEND -> (FETCH if index<NUM_LEDS-1, else LATCH) -> IDLE, or FETCH of pixel 0 if enable is high.
- IDLE: DO=0. The first cycle enable=1 is sampled moves to FETCH with index 0. mode and brightness are registered in this cycle and held for the whole frame.
- FETCH (1 cycle): address=index.
- LOAD (1 cycle): red_in/green_in/blue_in are captured. The pattern colour is computed and scaled, and the 24-bit shift register is loaded as {G,R,B}.
- Pattern colour for pixel index i:
  - mode 0: the captured inputs.
  - mode 1: the inputs captured at pixel 0.
  - mode 2: the pixel-0 inputs if i == phase mod NUM_LEDS, else 0.
  - mode 3: wheel(h) with h=(phase+i*HUE_STEP) mod 256. For h<85: R=255-3h, G=3h, B=0. For 85<=h<170, with k=h-85: R=0, G=255-3k, B=3k. For h>=170, with k=h-170: R=3k, G=0, B=255-3k.
- Scaling: each channel out = (c*(brightness+1))>>8, computed 16-bit, truncated to 8 bits. brightness=255 gives identity; brightness=0 gives all zero.
- SEND: 24 bits, MSB first, each CYC_BIT cycles. DO is high for the first CYC_T1H cycles for a 1 bit and CYC_T0H cycles for a 0 bit, then low for the remainder. There is no gap between bits. The inter-pixel low time is extended by exactly 2 cycles (FETCH+LOAD).
- LATCH: DO=0 for CYC_RST cycles. On the last cycle: frame_done=1 and phase increments (8-bit, 255 wraps to 0).
- Frame length from FETCH of pixel 0 to the frame_done cycle inclusive: NUM_LEDS*(2+24*CYC_BIT)+CYC_RST.
- enable deasserted mid-frame: the current frame finishes including LATCH, then the FSM returns to IDLE. Changes to mode or brightness mid-frame are ignored until the next frame.
- busy=0 only in IDLE. frame_done and a restart in the same cycle are legal; the next FETCH follows immediately.

Test Plan:
- Default params; hold reset low, toggle clk -> DO=0, busy=0, frame_done=0, phase=0, address=0. Assert reset mid-SEND -> DO drops before the next clk edge.
- NUM_LEDS=2, mode 0, brightness 255; green=0x00, red=0xFF, blue=0x0F; enable high for one frame -> per LED, 8 bits high 10/low 21 cycles, then 8 bits high 20/low 11, then blue 0000_1111. frame_done occurs 3492 cycles after the first FETCH; phase=1.
- mode 1, red=0xFF, brightness=127 -> red byte serialised as 0x7F; green/blue 0x00. brightness=0 -> all 48 bits are 0-codes.
- NUM_LEDS=4, mode 2, enable held for 5 frames -> lit LED index 0,1,2,3,0 in successive frames. After 256 frames phase wraps to 0.
- NUM_LEDS=4, mode 3, phase 0, brightness 255 -> LED0 R=255,G=0,B=0; LED1 (h=64) R=63,G=192,B=0; LED2 (h=128, k=43) R=0,G=126,B=129; LED3 (h=192, k=22) R=66,G=0,B=189.
- Drop enable mid-SEND of LED1 -> LED1 plus the remaining LEDs complete, then LATCH of 2000 cycles, frame_done pulses, then IDLE with busy=0. Change mode mid-frame -> no effect until the next frame.
